// File: rtl/riscv_defines.sv
// ============================================================================
// Module      : riscv_defines (package)
// Description : Shared types and constants for the fetch-stage branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_defines;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_RESET = WNT;
    localparam bp_ctr_t BP_CTR_ALLOC = WT;

endpackage

`default_nettype wire

// File: rtl/sat_counter2.sv
// ============================================================================
// Module      : sat_counter2
// Description : Next-state logic for a 2-bit saturating direction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter2
    import riscv_defines::*;
(
    input  bp_ctr_t ctr,
    input  logic    taken,
    output bp_ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            case (ctr)
                SNT:     ctr_next = WNT;
                WNT:     ctr_next = WT;
                WT:      ctr_next = ST;
                default: ctr_next = ST;
            endcase
        end else begin
            case (ctr)
                ST:      ctr_next = WT;
                WT:      ctr_next = WNT;
                WNT:     ctr_next = SNT;
                default: ctr_next = SNT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit direction counters, combinational
//               lookup, execute-stage training and mispredict redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
    import riscv_defines::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    output logic        pred_taken,
    output logic [31:0] pc_pred,
    input  logic        cflow_valid_e,
    input  logic [31:0] pc_e,
    input  logic        cflow_taken_e,
    input  logic [31:0] target_e,
    input  logic        pred_taken_e,
    input  logic [31:0] pred_target_e,
    input  logic        flush_e,
    output logic        mispredict
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    bp_ctr_t            ctr_q    [ENTRIES];

    logic [IDX-1:0]  idx_f;
    logic [TAGW-1:0] tag_f;
    logic            hit_f;
    logic [1:0]      ctr_f;

    logic [IDX-1:0]  idx_e;
    logic [TAGW-1:0] tag_e;
    logic            hit_e;
    logic            upd;
    bp_ctr_t         ctr_e;
    bp_ctr_t         ctr_e_next;

    logic            unused_low_bits;

    assign unused_low_bits = ^{pc_f[1:0], pc_e[1:0], target_e[1:0]};

    // Fetch-side lookup; no bypass from a same-cycle update.
    assign idx_f = pc_f[IDX+1:2];
    assign tag_f = pc_f[31:IDX+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign ctr_f = ctr_q[idx_f];

    assign pred_taken = !reset && hit_f && ctr_f[1];
    assign pc_pred    = (!reset && hit_f) ? {target_q[idx_f], 2'b00} : 32'h0;

    assign idx_e = pc_e[IDX+1:2];
    assign tag_e = pc_e[31:IDX+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign ctr_e = ctr_q[idx_e];
    assign upd   = cflow_valid_e && !flush_e;

    assign mispredict = !reset && upd &&
                        ((pred_taken_e ^ cflow_taken_e) ||
                         (cflow_taken_e && pred_taken_e && (pred_target_e != target_e)));

    sat_counter2 u_sat_counter2 (
        .ctr      (ctr_e),
        .taken    (cflow_taken_e),
        .ctr_next (ctr_e_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= BP_CTR_RESET;
            end
        end else if (upd) begin
            if (cflow_taken_e) begin
                target_q[idx_e] <= target_e[31:2];
                if (hit_e) begin
                    ctr_q[idx_e] <= ctr_e_next;
                end else begin
                    // Taken miss evicts whatever lived at this index.
                    valid_q[idx_e] <= 1'b1;
                    tag_q[idx_e]   <= tag_e;
                    ctr_q[idx_e]   <= BP_CTR_ALLOC;
                end
            end else if (hit_e) begin
                ctr_q[idx_e] <= ctr_e_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic [31:0] pc_pred;
    logic        cflow_valid_e;
    logic [31:0] pc_e;
    logic        cflow_taken_e;
    logic [31:0] target_e;
    logic        pred_taken_e;
    logic [31:0] pred_target_e;
    logic        flush_e;
    logic        mispredict;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_f          (pc_f),
        .pred_taken    (pred_taken),
        .pc_pred       (pc_pred),
        .cflow_valid_e (cflow_valid_e),
        .pc_e          (pc_e),
        .cflow_taken_e (cflow_taken_e),
        .target_e      (target_e),
        .pred_taken_e  (pred_taken_e),
        .pred_target_e (pred_target_e),
        .flush_e       (flush_e),
        .mispredict    (mispredict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_e();
        cflow_valid_e = 1'b0;
        pc_e          = 32'h0;
        cflow_taken_e = 1'b0;
        target_e      = 32'h0;
        pred_taken_e  = 1'b0;
        pred_target_e = 32'h0;
        flush_e       = 1'b0;
    endtask

    task automatic upd_e(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        cflow_valid_e = 1'b1;
        pc_e          = pc;
        cflow_taken_e = tk;
        target_e      = tgt;
        pred_taken_e  = 1'b0;
        pred_target_e = 32'h0;
        flush_e       = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_pc);
        pc_f = pc;
        #1;
        chk({tag, "_taken"}, {31'h0, pred_taken}, {31'h0, exp_t});
        chk({tag, "_pc"}, pc_pred, exp_pc);
    endtask

    // One training step at 0x100 followed by a lookup of the result.
    task automatic train(input string tag, input logic tk, input logic [31:0] tgt,
                         input logic exp_t, input logic [31:0] exp_pc);
        upd_e(32'h100, tk, tgt);
        tick();
        idle_e();
        look(tag, 32'h100, exp_t, exp_pc);
    endtask

    initial begin
        reset = 1'b1;
        pc_f  = 32'h100;
        idle_e();
        cflow_valid_e = 1'b1;
        pred_taken_e  = 1'b1;
        #1;
        chk("rst_pred", {31'h0, pred_taken}, 32'h0);
        chk("rst_pcpred", pc_pred, 32'h0);
        chk("rst_mispredict", {31'h0, mispredict}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        idle_e();
        tick();

        // Allocate 0x100 -> 0x200; same-cycle lookup sees the old contents.
        upd_e(32'h100, 1'b1, 32'h200);
        pc_f = 32'h100;
        #1;
        chk("alloc_mispredict", {31'h0, mispredict}, 32'h1);
        chk("alloc_same_cycle", {31'h0, pred_taken}, 32'h0);
        tick();
        idle_e();
        look("alloc_next", 32'h100, 1'b1, 32'h200);

        // Hysteresis: WT -> WNT -> SNT -> WNT, then up to ST and back down.
        upd_e(32'h100, 1'b0, 32'h0);
        #1;
        chk("hys_pre_update", {31'h0, pred_taken}, 32'h1);
        tick();
        idle_e();
        look("hys_nt1", 32'h100, 1'b0, 32'h200);
        train("hys_nt2", 1'b0, 32'h0,   1'b0, 32'h200);
        train("hys_t1",  1'b1, 32'h200, 1'b0, 32'h200);
        train("sat_t1",  1'b1, 32'h200, 1'b1, 32'h200);
        train("sat_t2",  1'b1, 32'h200, 1'b1, 32'h200);
        train("sat_t3",  1'b1, 32'h200, 1'b1, 32'h200);
        train("sat_t4",  1'b1, 32'h200, 1'b1, 32'h200);
        train("sat_nt1", 1'b0, 32'h0,   1'b1, 32'h200);
        train("sat_nt2", 1'b0, 32'h0,   1'b0, 32'h200);
        train("retarget", 1'b1, 32'h180, 1'b1, 32'h180);

        // Index conflict: 0x100, 0x200, 0x300 all map to index 0.
        upd_e(32'h200, 1'b1, 32'h400);
        tick();
        idle_e();
        look("conf_old", 32'h100, 1'b0, 32'h0);
        look("conf_new", 32'h200, 1'b1, 32'h400);
        upd_e(32'h300, 1'b0, 32'h0);
        tick();
        idle_e();
        look("conf_nt_keep", 32'h200, 1'b1, 32'h400);
        look("conf_nt_miss", 32'h300, 1'b0, 32'h0);

        // Mispredict combinations on a PC that is never looked up again.
        upd_e(32'h1000, 1'b0, 32'h0);
        pred_taken_e = 1'b1;
        #1;
        chk("mp_pt_nt", {31'h0, mispredict}, 32'h1);
        upd_e(32'h1000, 1'b1, 32'h204);
        pred_taken_e  = 1'b1;
        pred_target_e = 32'h200;
        #1;
        chk("mp_target_diff", {31'h0, mispredict}, 32'h1);
        target_e = 32'h200;
        #1;
        chk("mp_target_same", {31'h0, mispredict}, 32'h0);
        upd_e(32'h1000, 1'b0, 32'h0);
        #1;
        chk("mp_both_nt", {31'h0, mispredict}, 32'h0);
        upd_e(32'h1000, 1'b1, 32'h200);
        cflow_valid_e = 1'b0;
        #1;
        chk("mp_not_valid", {31'h0, mispredict}, 32'h0);
        idle_e();
        tick();

        // Flushed updates: no redirect and no BTB change.
        upd_e(32'h200, 1'b0, 32'h0);
        pred_taken_e = 1'b1;
        flush_e      = 1'b1;
        #1;
        chk("flush_mp_nt", {31'h0, mispredict}, 32'h0);
        tick();
        upd_e(32'h200, 1'b1, 32'h800);
        pred_taken_e  = 1'b1;
        pred_target_e = 32'h400;
        flush_e       = 1'b1;
        #1;
        chk("flush_mp_tgt", {31'h0, mispredict}, 32'h0);
        tick();
        upd_e(32'h2000, 1'b1, 32'h900);
        flush_e = 1'b1;
        tick();
        idle_e();
        look("flush_keep", 32'h200, 1'b1, 32'h400);
        look("flush_no_alloc", 32'h2000, 1'b0, 32'h0);

        // Populate an entry inside the swept range, then reset mid-cycle
        // with an update pending.
        upd_e(32'h40, 1'b1, 32'h500);
        tick();
        idle_e();
        look("pre_reset_40", 32'h40, 1'b1, 32'h500);
        upd_e(32'h200, 1'b1, 32'h600);
        #2;
        reset = 1'b1;
        for (int a = 0; a <= 32'hFC; a += 4) begin
            pc_f = a;
            #1;
            chk("rst_sweep_taken", {31'h0, pred_taken}, 32'h0);
            chk("rst_sweep_pc", pc_pred, 32'h0);
        end
        chk("rst_mid_mispredict", {31'h0, mispredict}, 32'h0);
        idle_e();
        tick();
        reset = 1'b0;
        tick();
        look("post_reset_40", 32'h40, 1'b0, 32'h0);
        look("post_reset_200", 32'h200, 1'b0, 32'h0);

        // Fresh counters start at WNT: a taken allocation yields WT again.
        upd_e(32'h40, 1'b1, 32'h700);
        tick();
        idle_e();
        look("realloc", 32'h40, 1'b1, 32'h700);
        upd_e(32'h40, 1'b0, 32'h0);
        tick();
        idle_e();
        look("realloc_nt", 32'h40, 1'b0, 32'h700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor paired with the next-PC mux: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It supplies `pred_taken` and `pc_pred` for the current fetch PC in the same cycle. It is trained by resolved control-flow results from execute, and from those results it also generates the `mispredict` redirect. It sits between the fetch PC register and the next-PC mux, with an update path from the execute stage.

## Interface
- `ENTRIES`, default 64: number of BTB entries; must be a power of two and at least 2. `IDX = $clog2(ENTRIES)`.
- `clk`  in  1  clock; every state element updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_f`  in  32  fetch PC being looked up.
- `pred_taken`  out  1  prediction for `pc_f`: taken.
- `pc_pred`  out  32  predicted target for `pc_f`; valid only when `pred_taken` is 1.
- `cflow_valid_e`  in  1  a branch or jump is resolving in execute this cycle.
- `pc_e`  in  32  PC of the resolving instruction.
- `cflow_taken_e`  in  1  actual outcome.
- `target_e`  in  32  actual target, meaningful only when the outcome is taken.
- `pred_taken_e`  in  1  fetch-time prediction, carried down the pipeline.
- `pred_target_e`  in  32  fetch-time target, carried down the pipeline.
- `flush_e`  in  1  execute slot is squashed (trap or older redirect); the update is suppressed.
- `mispredict`  out  1  redirect request to the next-PC mux.

## Operation
- Per-entry storage:
  - `valid`: 1 bit.
  - `tag`: `pc[31:IDX+2]`.
  - `target`: `[31:2]`; bits `[1:0]` are driven as 0.
  - `ctr`: 2 bits.
- Index is `pc[IDX+1:2]`. `pc[1:0]` is ignored.
- Counter encoding: `SNT=00`, `WNT=01`, `WT=10`, `ST=11`.
- Lookup is combinational:
  - hit = `valid` and tag match.
  - `pred_taken = hit & ctr[1]`.
  - `pc_pred = {target, 2'b00}` on a hit, otherwise 0.
- Update condition: `upd = cflow_valid_e & ~flush_e`.
- Update when the outcome is taken:
  - Hit: write `target ← target_e[31:2]` and increment `ctr`, saturating at `ST`.
  - Miss: allocate the entry (`valid=1`, new tag, new target, `ctr=WT`). Any previous occupant is replaced.
- Update when the outcome is not taken:
  - Hit: decrement `ctr`, saturating at `SNT`.
  - Miss: no write, no allocation.
- `mispredict = upd & ((pred_taken_e ^ cflow_taken_e) | (cflow_taken_e & pred_taken_e & (pred_target_e != target_e)))`.
- `mispredict` is combinational. The mux uses `cflow_taken` to choose between the jump target and the fall-through.
- `mispredict` is forced to 0 when `flush_e` is asserted.

## Timing
- Lookup has zero latency: `pred_taken` and `pc_pred` are valid in the same cycle as `pc_f`.
- An update is written at the rising edge ending the cycle in which `upd` is 1. It is visible to lookups from the next cycle onward.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents. There is no bypass.
- Reset is asynchronous:
  - All `valid` bits clear to 0 and all `ctr` clear to `WNT`.
  - `tag` and `target` are also cleared.
  - While `reset` is high: `pred_taken=0`, `pc_pred=0`, `mispredict=0`. `mispredict` is gated by `reset`.
- An update pending when `reset` asserts is lost.
- Tag aliasing is impossible for 32-bit PCs, since the full upper PC is stored. Index conflicts are resolved by replacement on a taken allocation only.

## Structure
- Shared package `riscv_defines`:
  - `typedef enum logic [1:0] {SNT, WNT, WT, ST} bp_ctr_t`.
  - `BP_CTR_RESET = WNT`.
  - `BP_CTR_ALLOC = WT`.
- Storage is flip-flop arrays, because reset must clear all entries. No SRAM macro is used.
- The natural sub-module is `sat_counter2`: pure combinational next-state logic with inputs `ctr` and `taken`. It is instantiated once, on the update path.

## Test plan
- **Reset:** assert `reset` mid-simulation, then drive `pc_f` values 0x0 through 0xFC.
  - Required: `pred_taken=0` and `pc_pred=0` for every PC.
- **Allocate:** taken update with `pc_e=0x100`, `target_e=0x200`.
  - Next cycle, `pc_f=0x100` gives `pred_taken=1`, `pc_pred=0x200`.
  - Same cycle as the update, `pc_f=0x100` still gives `pred_taken=0`.
- **Hysteresis:** from `WT` at 0x100, apply not-taken, not-taken, then taken.
  - `pred_taken` goes 1 → 0 → 0 → 0. Counter sequence is `WT`→`WNT`→`SNT`→`WNT`.
  - Four consecutive taken updates saturate the counter at `ST`.
- **Conflict:** with `ENTRIES=64`, allocate 0x100, then apply a taken update at 0x200, which has the same index.
  - `pc_f=0x100` then predicts not-taken; `pc_f=0x200` predicts taken.
  - A not-taken update at 0x300, also the same index, changes nothing.
- **Mispredict cases:**
  - `pred_taken_e=1`, `cflow_taken_e=0` → `mispredict=1`.
  - Both taken with `pred_target_e=0x200` and `target_e=0x204` → `mispredict=1`.
  - Both taken with equal targets → `mispredict=0`.
  - Both not-taken → `mispredict=0`.
- **Flush:** a mispredicting update with `flush_e=1`.
  - Required: `mispredict=0`, and the BTB entry is unchanged on the next-cycle lookup.
